// File: rtl/aes_stim_ctrl.sv
// Drives state/key increment pulses into the AES parity wrapper and folds its sampled output into a MISR.
// One vector per AES_LATENCY+2 cycles, no backpressure; `STIM_ABORT_EN adds an abort input that cancels a run.
module aes_stim_ctrl #(
  parameter int unsigned     AES_LATENCY = 21,
  parameter int unsigned     NUM_VECTORS = 16,
  parameter int unsigned     KEY_EVERY   = 4,
  parameter int unsigned     SIG_W       = 32,
  parameter logic [SIG_W-1:0] POLY       = SIG_W'(32'h04C11DB7)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef STIM_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             state_change,
  output logic             key_change,
  input  logic             dut_out,
  output logic [SIG_W-1:0] signature,
  output logic [15:0]      vec_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [7:0]  LAT_LD = 8'(AES_LATENCY);
  localparam logic [15:0] KEY_LD = 16'(KEY_EVERY);
  localparam logic [15:0] NV     = 16'(NUM_VECTORS);

  state_e             state_q, state_d;
  logic [7:0]         wait_q, wait_d;
  logic [15:0]        key_cnt_q, key_cnt_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [15:0]        vcnt_q, vcnt_d;
  logic               sc_q, sc_d;
  logic               kc_q, kc_d;

  logic               abort_w;
  logic               run_active;
  logic               kill;
  logic [15:0]        vec_inc;
  logic [SIG_W-1:0]   misr_next;

`ifdef STIM_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign run_active = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_SAMPLE);
  assign kill       = abort_w && run_active;
  assign vec_inc    = vcnt_q + 16'd1;
  assign misr_next  = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                    ^ {{(SIG_W-1){1'b0}}, dut_out};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT:   if (wait_q == 8'd1) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (vec_inc == NV) ? S_DONE : S_ISSUE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_comb begin
    wait_d    = wait_q;
    key_cnt_d = key_cnt_q;
    sig_d     = sig_q;
    vcnt_d    = vcnt_q;
    if (!kill) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sig_d     = '0;
            vcnt_d    = '0;
            key_cnt_d = KEY_LD;
          end
        end
        S_ISSUE: begin
          wait_d    = LAT_LD;
          key_cnt_d = (key_cnt_q == 16'd1) ? KEY_LD : key_cnt_q - 16'd1;
        end
        S_WAIT:   wait_d = wait_q - 8'd1;
        S_SAMPLE: begin
          sig_d  = misr_next;
          vcnt_d = vec_inc;
        end
        default: ;
      endcase
    end
    // Key counter is only decremented on leaving ISSUE, so on a fresh launch the reload value decides the first pulse.
    sc_d = (state_d == S_ISSUE);
    kc_d = sc_d && ((state_q == S_IDLE) ? (KEY_LD == 16'd1) : (key_cnt_q == 16'd1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q    <= '0;
      key_cnt_q <= '0;
      sig_q     <= '0;
      vcnt_q    <= '0;
      sc_q      <= 1'b0;
      kc_q      <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      key_cnt_q <= key_cnt_d;
      sig_q     <= sig_d;
      vcnt_q    <= vcnt_d;
      sc_q      <= sc_d;
      kc_q      <= kc_d;
    end
  end

  assign busy         = run_active;
  assign done         = (state_q == S_DONE);
  assign state_change = sc_q;
  assign key_change   = kc_q;
  assign signature    = sig_q;
  assign vec_count    = vcnt_q;

endmodule
